// File: rtl/narvie_uart_pkg.sv
// Shared UART constants and FSM state encoding for the narvie host link.
package narvie_uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 104;
  localparam int unsigned REGFILE_BYTES        = 128;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/regfile_dump_tx_if.sv
// Byte stream handshake between the dump sequencer and the UART byte transmitter.
interface regfile_dump_tx_if;

  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/regfile_dump_tx_tx_byte.sv
// 8N1 transmitter: one byte per valid/ready handshake, back-to-back frames with no idle gap.
module uart_tx_byte
  import narvie_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  regfile_dump_tx_if.slave   byte_if,
  output logic               tx_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  uart_state_e   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          baud_last;
  logic          accept;

  assign baud_last = (baud_q == CW'(CLKS_PER_BIT - 1));
  assign accept    = byte_if.valid && byte_if.ready;
  assign tx_o      = tx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= UART_IDLE;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (state_q != IDLE) begin
      baud_d = baud_last ? '0 : baud_q + CW'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shreg_d = byte_if.data;
          baud_d  = '0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_last) begin
          bit_d   = bit_q + 3'd1;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Taking the next byte on the final stop cycle keeps frames gapless.
        if (baud_last) begin
          if (accept) begin
            state_d = START;
            shreg_d = byte_if.data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_if.ready = (state_q == IDLE) || ((state_q == STOP) && baud_last);
    unique case (state_d)
      START:   tx_d = UART_START;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = UART_IDLE;
    endcase
  end

endmodule

// File: rtl/regfile_dump_tx.sv
// Snapshots the register file on request and streams it out LSB-byte-first, x0 to x31.
module regfile_dump_tx
  import narvie_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned NUM_REGS     = REGFILE_BYTES / 4
) (
  input  logic                    clk12,
  input  logic                    rstn,
  input  logic [NUM_REGS*32-1:0]  reg_file,
  input  logic                    do_write,
  output logic                    ready,
  output logic                    done,
  output logic                    tx
);

  localparam int unsigned NUM_BYTES = NUM_REGS * 4;
  localparam int unsigned IW        = $clog2(NUM_BYTES);

  logic [NUM_REGS*32-1:0] shadow_q;
  logic [IW-1:0]          byte_idx_q;
  logic [IW-1:0]          next_idx;
  logic                   busy_q;
  logic                   done_q;
  logic                   last_byte;

  regfile_dump_tx_if byte_if ();

  assign next_idx  = byte_idx_q + IW'(1);
  assign last_byte = (byte_idx_q == IW'(NUM_BYTES - 1));
  assign ready     = !busy_q;
  assign done      = done_q;

  // Byte 0 is fed straight from reg_file so the start bit can begin the cycle after accept.
  always_comb begin
    byte_if.valid = 1'b0;
    byte_if.data  = reg_file[7:0];
    if (!busy_q) begin
      byte_if.valid = do_write;
    end else begin
      byte_if.valid = !last_byte;
      byte_if.data  = shadow_q[8*next_idx +: 8];
    end
  end

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      shadow_q   <= '0;
      byte_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (do_write && byte_if.ready) begin
          shadow_q   <= reg_file;
          byte_idx_q <= '0;
          busy_q     <= 1'b1;
        end
      end else if (byte_if.ready) begin
        if (last_byte) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          byte_idx_q <= next_idx;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_i  (clk12),
    .rst_ni (rstn),
    .byte_if(byte_if.slave),
    .tx_o   (tx)
  );

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Scoreboard bench: expected bytes queued by stimulus, a UART monitor decodes tx and compares.
module tb_regfile_dump_tx;

  localparam int C  = 4;
  localparam int NB = 128;

  logic          clk12 = 1'b0;
  logic          rstn = 1'b0;
  logic          do_write = 1'b0;
  logic [1023:0] reg_file = '0;
  logic          ready, done, tx;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int bytes_rx = 0;
  logic [7:0] exp_q[$];

  regfile_dump_tx #(
    .CLKS_PER_BIT(C),
    .NUM_REGS(32)
  ) dut (
    .clk12   (clk12),
    .rstn    (rstn),
    .reg_file(reg_file),
    .do_write(do_write),
    .ready   (ready),
    .done    (done),
    .tx      (tx)
  );

  always #5 clk12 = ~clk12;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk12);
    cyc++;
  end

  initial forever begin
    @(negedge clk12);
    if (done === 1'b1) done_cnt++;
  end

  // UART monitor: samples mid-bit on negedges, aborts a frame on reset.
  initial begin
    bit   mon_active;
    int   mon_cnt;
    int   k;
    logic [7:0] mon_byte;
    mon_active = 0;
    mon_cnt    = 0;
    mon_byte   = '0;
    forever begin
      @(negedge clk12);
      if (!rstn) begin
        mon_active = 0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1;
          mon_cnt    = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % C == C / 2) begin
          k = mon_cnt / C;
          if (k == 0) begin
            check("start_bit", {63'd0, tx}, 64'd0);
          end else if (k <= 8) begin
            mon_byte[k-1] = tx;
          end else begin
            check("stop_bit", {63'd0, tx}, 64'd1);
            if (exp_q.size() == 0) begin
              check("unexpected_byte", {56'd0, mon_byte}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
              check("rx_byte", {56'd0, mon_byte}, {56'd0, exp_q.pop_front()});
            end
            bytes_rx++;
            mon_active = 0;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic accept(input bit hold, output int acc);
    @(negedge clk12);
    check("ready_before_accept", {63'd0, ready}, 64'd1);
    do_write = 1'b1;
    @(posedge clk12);
    #1;
    acc = cyc;
    if (!hold) do_write = 1'b0;
  endtask

  task automatic wait_done(input int acc, output int label);
    label = -1;
    for (int n = 0; n < NB * 10 * C + 50; n++) begin
      @(negedge clk12);
      if (done === 1'b1) begin
        label = cyc - acc + 1;
        break;
      end
    end
    if (label < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_bytes(input int target);
    int n;
    n = 0;
    while (bytes_rx < target && n < (NB * 10 * C + 50)) begin
      @(negedge clk12);
      n++;
    end
    if (bytes_rx < target) check("bytes_timeout", bytes_rx, target);
  endtask

  task automatic set_pattern();
    for (int i = 0; i < 32; i++) reg_file[32*i +: 32] = 32'hA0B0C000 | i;
  endtask

  task automatic push_pattern();
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(8'(i));
      exp_q.push_back(8'hC0);
      exp_q.push_back(8'hB0);
      exp_q.push_back(8'hA0);
    end
  endtask

  initial begin
    int acc, acc2, lbl, b0, d0;

    // reset and idle
    rstn = 1'b0;
    repeat (3) @(negedge clk12);
    check("rst_tx", {63'd0, tx}, 64'd1);
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_done", {63'd0, done}, 64'd0);
    rstn = 1'b1;
    repeat (100) begin
      @(negedge clk12);
      check("idle_tx", {63'd0, tx}, 64'd1);
      check("idle_ready", {63'd0, ready}, 64'd1);
      check("idle_done", {63'd0, done}, 64'd0);
    end

    // single dump, x1 = 11223344
    reg_file = '0;
    reg_file[63:32] = 32'h11223344;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h11);
    for (int i = 8; i < NB; i++) exp_q.push_back(8'h00);
    b0 = bytes_rx;
    d0 = done_cnt;
    accept(0, acc);
    @(negedge clk12);
    check("ready_low_cycle1", {63'd0, ready}, 64'd0);
    check("tx_start_cycle1", {63'd0, tx}, 64'd0);
    wait_done(acc, lbl);
    check("done_cycle", lbl, 5121);
    check("done_ready_same_cycle", {63'd0, ready}, 64'd1);
    @(negedge clk12);
    check("done_single_pulse", {63'd0, done}, 64'd0);
    check("bytes_single", bytes_rx - b0, NB);
    check("done_count_single", done_cnt - d0, 1);

    // snapshot isolation
    reg_file = '0;
    for (int i = 0; i < NB; i++) exp_q.push_back(8'h00);
    b0 = bytes_rx;
    accept(0, acc);
    @(negedge clk12);
    reg_file = '1;
    wait_done(acc, lbl);
    check("done_cycle_snapshot", lbl, 5121);
    check("bytes_snapshot", bytes_rx - b0, NB);

    // busy request ignored
    set_pattern();
    push_pattern();
    b0 = bytes_rx;
    d0 = done_cnt;
    accept(0, acc);
    wait_bytes(b0 + 50);
    @(negedge clk12);
    check("ready_busy", {63'd0, ready}, 64'd0);
    do_write = 1'b1;
    @(negedge clk12);
    do_write = 1'b0;
    wait_done(acc, lbl);
    check("done_cycle_busy", lbl, 5121);
    repeat (60) @(negedge clk12);
    check("bytes_busy", bytes_rx - b0, NB);
    check("done_count_busy", done_cnt - d0, 1);
    check("idle_after_busy_tx", {63'd0, tx}, 64'd1);

    // back-to-back with do_write held
    push_pattern();
    push_pattern();
    b0 = bytes_rx;
    accept(1, acc);
    wait_done(acc, lbl);
    check("done_cycle_b2b_1", lbl, 5121);
    check("b2b_ready_high", {63'd0, ready}, 64'd1);
    @(negedge clk12);
    check("b2b_ready_one_cycle", {63'd0, ready}, 64'd0);
    check("b2b_start_bit", {63'd0, tx}, 64'd0);
    check("b2b_start_cycle", cyc - acc + 1, 5122);
    acc2 = cyc;
    do_write = 1'b0;
    wait_done(acc2, lbl);
    check("done_cycle_b2b_2", lbl, 5121);
    @(negedge clk12);
    check("bytes_b2b", bytes_rx - b0, 2 * NB);

    // reset during DATA of byte 10
    push_pattern();
    b0 = bytes_rx;
    accept(0, acc);
    wait_bytes(b0 + 10);
    repeat (8) @(negedge clk12);
    check("pre_reset_tx_low", {63'd0, tx}, 64'd0);
    #1;
    rstn = 1'b0;
    #1;
    check("rst_async_tx", {63'd0, tx}, 64'd1);
    check("rst_async_ready", {63'd0, ready}, 64'd1);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk12);
    rstn = 1'b1;
    repeat (30) @(negedge clk12);
    check("no_done_after_reset", done_cnt - d0, 0);
    check("ready_after_reset", {63'd0, ready}, 64'd1);
    check("tx_after_reset", {63'd0, tx}, 64'd1);
    push_pattern();
    b0 = bytes_rx;
    accept(0, acc);
    wait_done(acc, lbl);
    check("done_cycle_after_reset", lbl, 5121);
    @(negedge clk12);
    check("bytes_after_reset", bytes_rx - b0, NB);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
